// File: rtl/paddle_capture.sv
// Per-frame paddle position capture: synchronizes the comparator and vsync inputs, then
// records the scanline of each paddle's first rise. Optional macro: PADDLE_CAPTURE_SMOOTH_EN.
module paddle_capture #(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_LINE      = 0,
  parameter int TIMEOUT_VALUE = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hpaddle,
  input  logic       vpaddle,
  input  logic       vsync,
  input  logic [8:0] vpos,
  output logic [7:0] paddle_x,
  output logic [7:0] paddle_y,
  output logic       x_present,
  output logic       y_present,
  output logic       frame_strobe
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURED} state_e;

  localparam logic [8:0] MIN_LINE_V = 9'(MIN_LINE);
  localparam logic [7:0] TIMEOUT_V  = 8'(TIMEOUT_VALUE);

  // Input index 0 = hpaddle, 1 = vpaddle, 2 = vsync.
  logic [2:0]             raw;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [SYNC_STAGES-1:0] sync_d [3];
  logic [2:0]             dly_q, dly_d;
  logic [2:0]             rise;

  state_e     state_q [2];
  state_e     state_d [2];
  logic [7:0] cap_q [2];
  logic [7:0] cap_d [2];
  logic [7:0] out_q [2];
  logic [7:0] out_d [2];
  logic [1:0] pres_q, pres_d;
  logic       strobe_q, strobe_d;
`ifdef PADDLE_CAPTURE_SMOOTH_EN
  logic [7:0] filt_q [2];
  logic [7:0] filt_d [2];
  logic [1:0] filt_ok_q, filt_ok_d;
`endif

  logic       frame_evt;
  logic [7:0] vpos_sat;

  assign raw       = {vsync, vpaddle, hpaddle};
  assign frame_evt = rise[2];
  assign vpos_sat  = vpos[8] ? 8'hFF : vpos[7:0];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      dly_d[i]  = sync_q[i][SYNC_STAGES-1];
      rise[i]   = sync_q[i][SYNC_STAGES-1] & ~dly_q[i];
    end
  end

  always_comb begin
    // NOTE: every next-state variable takes its held value first, so no path infers a latch.
    logic [8:0] filt_sum;
    filt_sum = '0;
    pres_d   = pres_q;
`ifdef PADDLE_CAPTURE_SMOOTH_EN
    filt_ok_d = filt_ok_q;
`endif
    for (int c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      cap_d[c]   = cap_q[c];
      out_d[c]   = out_q[c];
`ifdef PADDLE_CAPTURE_SMOOTH_EN
      filt_d[c]  = filt_q[c];
`endif
      case (state_q[c])
        IDLE: if (frame_evt) state_d[c] = ARMED;
        ARMED: begin
          // A rise coincident with the frame event is dropped, not credited to either frame.
          if (frame_evt) begin
            out_d[c]  = TIMEOUT_V;
            pres_d[c] = 1'b0;
            cap_d[c]  = '0;
`ifdef PADDLE_CAPTURE_SMOOTH_EN
            filt_ok_d[c] = 1'b0;
`endif
          end else if (rise[c] && vpos >= MIN_LINE_V) begin
            cap_d[c]   = vpos_sat;
            state_d[c] = CAPTURED;
          end
        end
        CAPTURED: begin
          if (frame_evt) begin
            pres_d[c]  = 1'b1;
            cap_d[c]   = '0;
            state_d[c] = ARMED;
`ifdef PADDLE_CAPTURE_SMOOTH_EN
            filt_sum     = {1'b0, filt_q[c]} + {1'b0, cap_q[c]} + 9'd1;
            filt_d[c]    = filt_ok_q[c] ? filt_sum[8:1] : cap_q[c];
            filt_ok_d[c] = 1'b1;
            out_d[c]     = filt_d[c];
`else
            out_d[c]     = cap_q[c];
`endif
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
    // Both channels leave IDLE together; the arming frame produces no update.
    strobe_d = frame_evt && (state_q[0] != IDLE);
  end

  // NOTE: all state, including capture and filter registers, is reset so nothing is X after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) sync_q[i] <= '0;
      dly_q    <= '0;
      pres_q   <= '0;
      strobe_q <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= IDLE;
        cap_q[c]   <= '0;
        out_q[c]   <= '0;
`ifdef PADDLE_CAPTURE_SMOOTH_EN
        filt_q[c]  <= '0;
`endif
      end
`ifdef PADDLE_CAPTURE_SMOOTH_EN
      filt_ok_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      for (int i = 0; i < 3; i++) sync_q[i] <= sync_d[i];
      dly_q    <= dly_d;
      pres_q   <= pres_d;
      strobe_q <= strobe_d;
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        cap_q[c]   <= cap_d[c];
        out_q[c]   <= out_d[c];
`ifdef PADDLE_CAPTURE_SMOOTH_EN
        filt_q[c]  <= filt_d[c];
`endif
      end
`ifdef PADDLE_CAPTURE_SMOOTH_EN
      filt_ok_q <= filt_ok_d;
`endif
    end
  end

  assign paddle_x     = out_q[0];
  assign paddle_y     = out_q[1];
  assign x_present    = pres_q[0];
  assign y_present    = pres_q[1];
  assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_paddle_capture.sv
// Scoreboard bench for paddle_capture: frames push expected outputs, a negedge monitor
// pops one entry per frame_strobe and compares.
module tb_paddle_capture;

  localparam int SS   = 2;
  localparam int HOLD = SS + 2;
`ifdef PADDLE_CAPTURE_SMOOTH_EN
  localparam bit SM = 1'b1;
`else
  localparam bit SM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, hpaddle, vpaddle, vsync;
  logic [8:0] vpos;
  logic [7:0] paddle_x, paddle_y;
  logic       x_present, y_present, frame_strobe;

  int vectors     = 0;
  int miscompares = 0;
  logic [17:0] sb [$];
  logic [17:0] last_exp;

  paddle_capture #(.SYNC_STAGES(SS), .MIN_LINE(8), .TIMEOUT_VALUE(255)) dut (
    .clk(clk), .reset(reset), .hpaddle(hpaddle), .vpaddle(vpaddle), .vsync(vsync),
    .vpos(vpos), .paddle_x(paddle_x), .paddle_y(paddle_y), .x_present(x_present),
    .y_present(y_present), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] pack(input int x, input int y, input bit xp, input bit yp);
    return {8'(x), 8'(y), xp, yp};
  endfunction

  function automatic logic [17:0] outs();
    return {paddle_x, paddle_y, x_present, y_present};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ch 0 = hpaddle, 1 = vpaddle; vpos held steady across the whole pulse.
  task automatic pulse(input bit ch, input int v);
    vpos = 9'(v);
    if (ch) vpaddle = 1'b1; else hpaddle = 1'b1;
    cycles(HOLD);
    if (ch) vpaddle = 1'b0; else hpaddle = 1'b0;
    cycles(HOLD);
  endtask

  task automatic frame(input bit expect_strobe, input logic [17:0] exp, input bit h_with_vsync);
    check("hold", 32'(outs()), 32'(last_exp));
    if (expect_strobe) begin
      sb.push_back(exp);
      last_exp = exp;
    end
    vpos  = 9'd400;
    vsync = 1'b1;
    if (h_with_vsync) hpaddle = 1'b1;
    cycles(HOLD);
    vsync = 1'b0;
    if (h_with_vsync) hpaddle = 1'b0;
    cycles(HOLD);
    check("strobe_seen", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (frame_strobe) begin
      if (sb.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else check("frame_out", 32'(outs()), 32'(sb.pop_front()));
    end
  end

  initial begin
    reset = 1'b0; hpaddle = 1'b0; vpaddle = 1'b0; vsync = 1'b0; vpos = '0;
    last_exp = '0;
    cycles(10);
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_strobe", 32'(frame_strobe), 32'd0);
    reset = 1'b1;
    cycles(2);

    frame(1'b0, '0, 1'b0);                                       // arms only
    pulse(0, 100); pulse(1, 37);
    frame(1'b1, pack(100, 37, 1, 1), 1'b0);
    pulse(0, 51);
    frame(1'b1, pack(SM ? 76 : 51, 255, 1, 0), 1'b0);
    pulse(0, 3); pulse(0, 50); pulse(0, 60); pulse(1, 200);
    frame(1'b1, pack(SM ? 63 : 50, 200, 1, 1), 1'b0);
    pulse(1, 10);
    frame(1'b1, pack(255, SM ? 105 : 10, 0, 1), 1'b1);           // h rise coincides with vsync
    pulse(1, 20);
    frame(1'b1, pack(255, SM ? 63 : 20, 0, 1), 1'b0);
    pulse(0, 300); pulse(1, 7);
    frame(1'b1, pack(255, 255, 1, 0), 1'b0);
    vpos = 9'd90; hpaddle = 1'b1;
    cycles(HOLD);
    frame(1'b1, pack(SM ? 173 : 90, 255, 1, 0), 1'b0);
    frame(1'b1, pack(255, 255, 0, 0), 1'b0);                     // held high: no new rise
    hpaddle = 1'b0;
    cycles(HOLD);

    pulse(0, 40);
    reset = 1'b0;
    #1;
    check("midframe_reset_outs", 32'(outs()), 32'd0);
    check("midframe_reset_strobe", 32'(frame_strobe), 32'd0);
    cycles(3);
    reset = 1'b1;
    last_exp = '0;
    cycles(2);
    frame(1'b0, '0, 1'b0);
    pulse(0, 33);
    frame(1'b1, pack(33, 255, 1, 0), 1'b0);
    check("final_hold", 32'(outs()), 32'(last_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/paddle_capture.md
Name: paddle_capture

Overview:
- Synchronous front end for the analog paddle comparator inputs.
- Sits directly upstream of the paddle-driven display/game logic and consumes hvsync_generator's vsync/vpos.
- Measures, per frame, the scanline on which each paddle comparator output first rises. Presents both results as stable 8-bit positions updated once per frame at vsync.
- Replaces ad-hoc edge-clocked capture: all state is clocked on clk only.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the input synchronizers for hpaddle, vpaddle and vsync. Legal range 2..4.
- MIN_LINE, 0: paddle rises with vpos below this value are ignored. Masks the comparator discharge glitch.
- TIMEOUT_VALUE, 255: position reported for a channel that saw no valid rise during the frame.

Ports:
- clk  in  1  system clock, same domain as hvsync_generator
- reset  in  1  asynchronous, active-low reset
- hpaddle  in  1  horizontal paddle comparator output; asynchronous
- vpaddle  in  1  vertical paddle comparator output; asynchronous
- vsync  in  1  vertical sync from hvsync_generator; active-high pulse
- vpos  in  9  current scanline from hvsync_generator
- paddle_x  out  8  last completed horizontal paddle measurement
- paddle_y  out  8  last completed vertical paddle measurement
- x_present  out  1  1 = paddle_x came from a real edge; 0 = timeout
- y_present  out  1  1 = paddle_y came from a real edge; 0 = timeout
- frame_strobe  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous release):
  - paddle_x=0, paddle_y=0, x_present=0, y_present=0, frame_strobe=0.
  - Synchronizers cleared; both channel FSMs in IDLE.
- Synchronizers: hpaddle, vpaddle and vsync each pass through SYNC_STAGES flops, then one extra flop for edge detect.
  - rise = synced & ~delayed.
  - A raw input transition is therefore detected on clock edge SYNC_STAGES+1 after it is first sampled.
- Frame event: a rise on synced vsync.
- Per-channel FSM (x and y identical and independent):
  - IDLE: on frame event -> ARMED. Outputs not updated, because the first frame after reset is partial.
  - ARMED: on paddle rise with vpos >= MIN_LINE:
    - capture sat8(vpos), where vpos > 255 gives 255, else vpos[7:0];
    - -> CAPTURED.
    - A rise with vpos < MIN_LINE is ignored; the channel stays ARMED.
  - CAPTURED: further rises ignored until the next frame event.
  - On frame event from ARMED or CAPTURED:
    - CAPTURED: output <= captured value, present <= 1.
    - ARMED: output <= TIMEOUT_VALUE, present <= 0.
    - Either way -> ARMED and the capture register is cleared.
- vpos is sampled on the same clk edge that detects the paddle rise.
- Output latency: paddle_x/y, x_present/y_present and frame_strobe all change on the clock edge that detects the frame event. frame_strobe is high for exactly that one cycle.
- Between frame events, outputs hold steady.
- Simultaneous paddle rise and frame event on the same cycle: the frame event wins. The edge is discarded and not counted toward either frame.
- A paddle held high through the frame boundary produces no new rise, so the next frame reports a timeout.
- A reset asserted mid-frame aborts everything immediately and returns to the reset state. The next frame event only arms the channels.

Optional Feature:
- Macro: PADDLE_CAPTURE_SMOOTH_EN.
- Defined:
  - Each channel keeps a filtered value: on a CAPTURED frame event, filt <= (filt + sample + 1) >> 1, using 9-bit intermediate arithmetic and round-half-up.
  - paddle_x/y output filt.
  - The first captured sample after reset, or after a timeout frame, loads filt directly.
  - Timeout frames output TIMEOUT_VALUE and do not modify filt.
- Undefined: raw captured value output as described above; no filter registers exist.

Test Plan:
- Reset held low 10 cycles, released; first vsync rise -> frame_strobe stays 0, outputs 0/0, present 0/0.
- Second frame: hpaddle rises while vpos=100, vpaddle rises while vpos=37; next vsync -> paddle_x=100, paddle_y=37, x_present=y_present=1, one-cycle frame_strobe.
- Frame with no vpaddle rise -> paddle_y=255, y_present=0; paddle_x unaffected by y.
- MIN_LINE=8: hpaddle pulses at vpos=3 and again at vpos=50 -> paddle_x=50. A further pulse at vpos=60 in the same frame -> still 50.
- hpaddle rise detected on the same cycle as the vsync rise -> edge discarded; next-frame paddle_x=255 unless another rise occurs. vpos=300 rise -> 255 with x_present=1.
- PADDLE_CAPTURE_SMOOTH_EN defined: samples 100 then 51 -> outputs 100, then 76. Reset asserted mid-frame -> outputs immediately 0.
